// File: rtl/uart_autobaud.sv
// uart_autobaud: measures a 0x55 sync character on rx and derives the bit period
// (bit_cycles) and the 8x-oversample divider from the F0..F4 span of eight bit times.
// Optional feature: define UART_AUTOBAUD_TOLERANCE_EN to reject characters whose
// F2..F4 intervals deviate from the F1 interval by more than a quarter of it.
module uart_autobaud #(
    parameter int unsigned BUS_CLK      = 10_000_000,
    parameter int unsigned DEFAULT_BAUD = 9600,
    parameter int unsigned DIV_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 start,
    output logic [DIV_WIDTH-1:0] divider,
    output logic [DIV_WIDTH+2:0] bit_cycles,
    output logic                 locked,
    output logic                 busy,
    output logic                 err
);
    localparam int unsigned CW = DIV_WIDTH + 6;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(BUS_CLK / (8 * DEFAULT_BAUD));
    localparam logic [DIV_WIDTH+2:0] DEF_BIT = (DIV_WIDTH + 3)'(BUS_CLK / DEFAULT_BAUD);

    typedef enum logic [2:0] {StIdle, StWaitIdle, StWaitStart, StMeasure, StCheckStop} state_t;

    state_t               r_state, w_state_next;
    logic                 r_rx_s1, r_rx_s2, r_rx_d;
    logic [CW-1:0]        r_total, r_iv, r_i1;
    logic [1:0]           r_fcnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH+2:0] r_bit;
    logic                 r_locked, r_busy, r_err;

    logic                 w_fall, w_rise, w_tot_sat, w_iv_sat, w_tol_bad;
    logic [CW-1:0]        w_tot_inc, w_iv_inc;
    logic                 w_arm, w_clr, w_restart, w_latch_i1, w_lock, w_fail;

    assign w_fall    = r_rx_d & ~r_rx_s2;
    assign w_rise    = ~r_rx_d & r_rx_s2;
    assign w_tot_sat = (r_total == CNT_MAX);
    assign w_iv_sat  = (r_iv == CNT_MAX);
    // Count including the current cycle, clamped so the counters never wrap.
    assign w_tot_inc = w_tot_sat ? r_total : r_total + 1'b1;
    assign w_iv_inc  = w_iv_sat ? r_iv : r_iv + 1'b1;

`ifdef UART_AUTOBAUD_TOLERANCE_EN
    logic [CW-1:0] w_dev;
    assign w_dev     = (w_iv_inc > r_i1) ? (w_iv_inc - r_i1) : (r_i1 - w_iv_inc);
    assign w_tol_bad = (w_dev > (r_i1 >> 2));
`else
    assign w_tol_bad = 1'b0;
`endif

    assign divider    = r_div;
    assign bit_cycles = r_bit;
    assign locked     = r_locked;
    assign busy       = r_busy;
    assign err        = r_err;

    // Two-flop synchronizer plus delayed copy for edge detection; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:      if (w_arm) w_state_next = StWaitIdle;
            StWaitIdle:  if (r_rx_s2) w_state_next = StWaitStart;
            StWaitStart: if (w_clr) w_state_next = StMeasure;
            StMeasure: begin
                if (w_fail) begin
                    w_state_next = StIdle;
                end else if (w_fall && (r_fcnt == 2'd3)) begin
                    w_state_next = StCheckStop;
                end
            end
            StCheckStop: if (w_lock || w_fail) w_state_next = StIdle;
            default:     w_state_next = StIdle;
        endcase
    end

    // FSM control strobes: arm, counter clear/restart, completion and failure.
    always_comb begin
        w_arm      = 1'b0;
        w_clr      = 1'b0;
        w_restart  = 1'b0;
        w_latch_i1 = 1'b0;
        w_lock     = 1'b0;
        w_fail     = 1'b0;
        case (r_state)
            StIdle:      w_arm = start;
            StWaitStart: w_clr = w_fall;
            StMeasure: begin
                if (w_tot_sat || w_iv_sat) begin
                    w_fail = 1'b1;
                end else if (w_fall) begin
                    w_restart = 1'b1;
                    if (r_fcnt == 2'd0) begin
                        w_latch_i1 = 1'b1;
                    end else if (w_tol_bad) begin
                        w_fail = 1'b1;
                    end else if ((r_fcnt == 2'd3) && (w_tot_inc[CW-1:6] == '0)) begin
                        // Divider would be zero: character far too fast to use.
                        w_fail = 1'b1;
                    end
                end
            end
            StCheckStop: begin
                if (w_rise) begin
                    w_lock = 1'b1;
                end else if (w_iv_sat || (w_iv_inc >= r_i1)) begin
                    w_fail = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Measurement counters; total freezes after F4 and holds the 8-bit-time span.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total <= '0;
            r_iv    <= '0;
            r_i1    <= '0;
            r_fcnt  <= '0;
        end else if (w_clr) begin
            r_total <= '0;
            r_iv    <= '0;
            r_fcnt  <= '0;
        end else if (r_state == StMeasure) begin
            r_total <= w_tot_inc;
            r_iv    <= w_restart ? '0 : w_iv_inc;
            if (w_restart) r_fcnt <= r_fcnt + 2'd1;
            if (w_latch_i1) r_i1 <= w_iv_inc;
        end else if (r_state == StCheckStop) begin
            r_iv <= w_iv_inc;
        end
    end

    // Result and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div    <= DEF_DIV;
            r_bit    <= DEF_BIT;
            r_locked <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_arm) begin
                r_busy <= 1'b1;
                r_err  <= 1'b0;
            end
            if (w_lock) begin
                r_bit    <= r_total[CW-1:3];
                r_div    <= r_total[CW-1:6];
                r_locked <= 1'b1;
                r_busy   <= 1'b0;
            end
            if (w_fail) begin
                r_err  <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

endmodule
